// File: rtl/element_scanner_if.sv
// -----------------------------------------------------------------------------
// element_scanner_if
//
// Element-table write bus between the game logic and element_scanner.
//   wr_en     : write strobe; the addressed entry is fully overwritten
//   wr_addr   : table entry to write (0 = highest priority)
//   wr_valid  : entry enable
//   wr_type   : element type (0 ship, 1-3 aliens, 4 explosion, 5 rocket)
//   wr_x/wr_y : element left/top edge in pixels
//   wr_color  : sprite colour code
// Modports: master = game logic (drives), slave = element_scanner (receives).
// -----------------------------------------------------------------------------
interface element_scanner_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       wr_valid;
    logic [2:0] wr_type;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [1:0] wr_color;

    modport master (
        output wr_en, wr_addr, wr_valid, wr_type, wr_x, wr_y, wr_color
    );

    modport slave (
        input  wr_en, wr_addr, wr_valid, wr_type, wr_x, wr_y, wr_color
    );
endinterface

// File: rtl/element_scanner.sv
// -----------------------------------------------------------------------------
// element_scanner
//
// Per-scanline object selector feeding pixel_graphics. Holds a table of
// NUM_ENTRIES elements written through the wr interface. During each
// horizontal blank it walks the table (one entry per cycle, starting at
// x == H_ACTIVE) and collects up to LINE_SLOTS elements overlapping the next
// visible line. At x == H_TOTAL-1 that list becomes the active list. During
// active video it emits, per pixel, the highest-priority element covering it.
//
// Ports:
//   pixel_clk     : the only clock
//   rst_n         : synchronous, active-low reset
//   x, y          : current timing-generator counters
//   wr            : element-table write bus (slave side)
//   x_out, y_out  : x, y delayed one cycle (aligned with element outputs)
//   hit           : an element covers (x_out, y_out)
//   element_type  : covering element type, 3'b110 (NONE) when no hit
//   element_x/_y  : covering element top-left, 0 when no hit
//   sprite_color  : covering element colour, 0 when no hit
//   line_overflow : one-cycle pulse (with x_out == first blank cycle after the
//                   scan) when a scan found more than LINE_SLOTS matches
// -----------------------------------------------------------------------------
module element_scanner #(
    parameter int NUM_ENTRIES = 16,
    parameter int LINE_SLOTS  = 4,
    parameter int SPRITE_W    = 32,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525
) (
    input  logic                    pixel_clk,
    input  logic                    rst_n,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    element_scanner_if.slave        wr,
    output logic [9:0]              x_out,
    output logic [9:0]              y_out,
    output logic                    hit,
    output logic [2:0]              element_type,
    output logic [9:0]              element_x,
    output logic [9:0]              element_y,
    output logic [1:0]              sprite_color,
    output logic                    line_overflow
);

    localparam int IDX_W  = $clog2(NUM_ENTRIES);
    localparam int CNT_W  = $clog2(LINE_SLOTS + 1);
    localparam int SLOT_W = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;

    localparam logic [9:0]       X_SCAN    = 10'(H_ACTIVE);
    localparam logic [9:0]       X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0]      SPR_W11   = 11'(SPRITE_W);
    localparam logic [2:0]       TYPE_NONE = 3'b110;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LINE_SLOTS);

    typedef struct packed {
        logic       valid;
        logic [2:0] etype;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [1:0] color;
    } elem_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Element table
    // ------------------------------------------------------------------
    elem_t tbl_q [NUM_ENTRIES];
    elem_t tbl_d [NUM_ENTRIES];

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            tbl_d[i] = tbl_q[i];
            if (wr.wr_en && (wr.wr_addr == IDX_W'(i))) begin
                tbl_d[i].valid = wr.wr_valid;
                tbl_d[i].etype = wr.wr_type;
                tbl_d[i].ex    = wr.wr_x;
                tbl_d[i].ey    = wr.wr_y;
                tbl_d[i].color = wr.wr_color;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scanner state
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       t_q, t_d;
    logic             ovf_pend_q, ovf_pend_d;
    elem_t            nxt_q [LINE_SLOTS];
    elem_t            nxt_d [LINE_SLOTS];
    logic [CNT_W-1:0] nxt_cnt_q, nxt_cnt_d;
    elem_t            act_q [LINE_SLOTS];
    elem_t            act_d [LINE_SLOTS];
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
    logic             line_overflow_q, line_overflow_d;

    logic             scan_start;
    logic             scan_en;
    logic [IDX_W-1:0] scan_idx;
    logic [9:0]       scan_t;
    logic [9:0]       t_line;
    elem_t            scan_e;
    logic             scan_match;

    // Target line wraps from the last line straight to line 0.
    assign t_line = (y == Y_LAST) ? 10'd0 : y + 10'd1;

    // Entry 0 is tested in the very cycle x == H_ACTIVE (while still IDLE),
    // so entry i is read at x == H_ACTIVE + i. The table is read from the
    // registered copy, so a same-cycle write to that entry is not seen.
    assign scan_start = (state_q == ST_IDLE) && (x == X_SCAN);
    assign scan_en    = scan_start || (state_q == ST_SCAN);
    assign scan_idx   = scan_start ? '0 : idx_q;
    assign scan_t     = scan_start ? t_line : t_q;
    assign scan_e     = tbl_q[scan_idx];

    // 11-bit compare so an element near the bottom never wraps into line 0.
    assign scan_match = scan_e.valid
                     && ({1'b0, scan_t} >= {1'b0, scan_e.ey})
                     && ({1'b0, scan_t} <  ({1'b0, scan_e.ey} + SPR_W11));

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        t_d             = t_q;
        ovf_pend_d      = ovf_pend_q;
        nxt_d           = nxt_q;
        nxt_cnt_d       = nxt_cnt_q;
        act_d           = act_q;
        act_cnt_d       = act_cnt_q;
        line_overflow_d = 1'b0;

        if (scan_start) begin
            nxt_cnt_d  = '0;
            ovf_pend_d = 1'b0;
            t_d        = t_line;
        end

        if (scan_en) begin
            if (scan_match) begin
                if (nxt_cnt_d < CNT_FULL) begin
                    nxt_d[nxt_cnt_d[SLOT_W-1:0]] = scan_e;
                    nxt_cnt_d = nxt_cnt_d + 1'b1;
                end else begin
                    ovf_pend_d = 1'b1;
                end
            end
            if (scan_idx == IDX_LAST) begin
                state_d = ST_WAIT;
            end else begin
                idx_d   = scan_idx + 1'b1;
                state_d = ST_SCAN;
            end
        end

        // First WAIT cycle reports the overflow once, then forgets it.
        if (state_q == ST_WAIT) begin
            line_overflow_d = ovf_pend_q;
            ovf_pend_d      = 1'b0;
        end

        // End of line: hand the collected list to the pixel side and empty
        // the next list, so a line whose scan never ran shows nothing.
        if (x == X_LAST) begin
            act_d     = nxt_d;
            act_cnt_d = nxt_cnt_d;
            nxt_cnt_d = '0;
            state_d   = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Pixel select
    // ------------------------------------------------------------------
    logic       slot_hit [LINE_SLOTS];
    logic       x_visible;
    logic       hit_q, hit_d;
    logic [2:0] element_type_q, element_type_d;
    logic [9:0] element_x_q, element_x_d;
    logic [9:0] element_y_q, element_y_d;
    logic [1:0] sprite_color_q, sprite_color_d;
    logic [9:0] x_out_q, y_out_q;

    assign x_visible = (x < X_SCAN);

    generate
        for (genvar gi = 0; gi < LINE_SLOTS; gi++) begin : g_slot
            assign slot_hit[gi] = (CNT_W'(gi) < act_cnt_q)
                               && x_visible
                               && ({1'b0, x} >= {1'b0, act_q[gi].ex})
                               && ({1'b0, x} <  ({1'b0, act_q[gi].ex} + SPR_W11));
        end
    endgenerate

    // Walk from the last slot down so the lowest (highest priority) hit wins.
    always_comb begin
        hit_d          = 1'b0;
        element_type_d = TYPE_NONE;
        element_x_d    = '0;
        element_y_d    = '0;
        sprite_color_d = '0;
        for (int s = LINE_SLOTS - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                hit_d          = 1'b1;
                element_type_d = act_q[s].etype;
                element_x_d    = act_q[s].ex;
                element_y_d    = act_q[s].ey;
                sprite_color_d = act_q[s].color;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            t_q             <= '0;
            ovf_pend_q      <= 1'b0;
            nxt_cnt_q       <= '0;
            act_cnt_q       <= '0;
            for (int i = 0; i < LINE_SLOTS; i++) begin
                nxt_q[i] <= '0;
                act_q[i] <= '0;
            end
            line_overflow_q <= 1'b0;
            hit_q           <= 1'b0;
            element_type_q  <= TYPE_NONE;
            element_x_q     <= '0;
            element_y_q     <= '0;
            sprite_color_q  <= '0;
            x_out_q         <= '0;
            y_out_q         <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            t_q             <= t_d;
            ovf_pend_q      <= ovf_pend_d;
            nxt_cnt_q       <= nxt_cnt_d;
            act_cnt_q       <= act_cnt_d;
            for (int i = 0; i < LINE_SLOTS; i++) begin
                nxt_q[i] <= nxt_d[i];
                act_q[i] <= act_d[i];
            end
            line_overflow_q <= line_overflow_d;
            hit_q           <= hit_d;
            element_type_q  <= element_type_d;
            element_x_q     <= element_x_d;
            element_y_q     <= element_y_d;
            sprite_color_q  <= sprite_color_d;
            x_out_q         <= x;
            y_out_q         <= y;
        end
    end

    assign x_out         = x_out_q;
    assign y_out         = y_out_q;
    assign hit           = hit_q;
    assign element_type  = element_type_q;
    assign element_x     = element_x_q;
    assign element_y     = element_y_q;
    assign sprite_color  = sprite_color_q;
    assign line_overflow = line_overflow_q;

endmodule

// File: tb/tb_element_scanner.sv
// -----------------------------------------------------------------------------
// tb_element_scanner
//
// Directed bench for element_scanner. Each line is driven x = 0..799 at a
// fixed y; after every clock edge the outputs are sampled and folded into
// per-line statistics (hit count, first/last hit, element fields at the first
// hit, overflow pulses) which are compared against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_element_scanner;

    logic       pixel_clk = 1'b0;
    logic       rst_n;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] x_out;
    logic [9:0] y_out;
    logic       hit;
    logic [2:0] element_type;
    logic [9:0] element_x;
    logic [9:0] element_y;
    logic [1:0] sprite_color;
    logic       line_overflow;

    element_scanner_if wr_if ();

    element_scanner dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .x             (x),
        .y             (y),
        .wr            (wr_if.slave),
        .x_out         (x_out),
        .y_out         (y_out),
        .hit           (hit),
        .element_type  (element_type),
        .element_x     (element_x),
        .element_y     (element_y),
        .sprite_color  (sprite_color),
        .line_overflow (line_overflow)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Per-line statistics filled by run_line.
    int ln_hits, ln_first, ln_last, ln_type, ln_ex, ln_ey, ln_col, ln_yout;
    int ln_ovf, ln_ovf_x, ln_type5;
    bit ln_map [800];
    int bad_align = 0;
    int bad_none  = 0;
    int rs_snap [8];

    // Optional in-line events: write or reset at a given x (-1 = none).
    int wr_at  = -1;
    int rst_at = -1;
    int w_addr, w_valid, w_type, w_x, w_y, w_col;

    task automatic drive_wr();
        wr_if.wr_addr  = 4'(w_addr);
        wr_if.wr_valid = w_valid[0];
        wr_if.wr_type  = 3'(w_type);
        wr_if.wr_x     = 10'(w_x);
        wr_if.wr_y     = 10'(w_y);
        wr_if.wr_color = 2'(w_col);
    endtask

    task automatic write_entry(input int a, input int v, input int t,
                               input int ex, input int ey, input int c);
        w_addr = a; w_valid = v; w_type = t; w_x = ex; w_y = ey; w_col = c;
        x = 10'd0;
        y = 10'd0;
        drive_wr();
        wr_if.wr_en = 1'b1;
        @(posedge pixel_clk); #1;
        wr_if.wr_en = 1'b0;
    endtask

    task automatic run_line(input int ly);
        ln_hits = 0; ln_first = -1; ln_last = -1; ln_type = -1;
        ln_ex = -1; ln_ey = -1; ln_col = -1; ln_yout = -1;
        ln_ovf = 0; ln_ovf_x = -1; ln_type5 = 0;
        for (int xi = 0; xi < 800; xi++) begin
            x = 10'(xi);
            y = 10'(ly);
            rst_n = (xi != rst_at);
            if (xi == wr_at) begin
                drive_wr();
                wr_if.wr_en = 1'b1;
            end else begin
                wr_if.wr_en = 1'b0;
            end
            @(posedge pixel_clk); #1;
            wr_if.wr_en = 1'b0;
            rst_n = 1'b1;
            ln_map[xi] = hit;
            if (xi == rst_at) begin
                rs_snap[0] = int'(x_out);        rs_snap[1] = int'(y_out);
                rs_snap[2] = int'(hit);          rs_snap[3] = int'(element_type);
                rs_snap[4] = int'(element_x);    rs_snap[5] = int'(element_y);
                rs_snap[6] = int'(sprite_color); rs_snap[7] = int'(line_overflow);
            end else if (int'(x_out) != xi || int'(y_out) != ly) begin
                bad_align++;
            end
            if (!hit && (element_type != 3'b110 || element_x != 10'd0 ||
                         element_y != 10'd0 || sprite_color != 2'd0))
                bad_none++;
            if (hit) begin
                ln_hits++;
                if (ln_first < 0) begin
                    ln_first = xi;
                    ln_type  = int'(element_type);
                    ln_ex    = int'(element_x);
                    ln_ey    = int'(element_y);
                    ln_col   = int'(sprite_color);
                    ln_yout  = int'(y_out);
                end
                ln_last = xi;
                if (element_type == 3'd5) ln_type5++;
            end
            if (line_overflow) begin
                ln_ovf++;
                ln_ovf_x = int'(x_out);
            end
        end
        wr_at  = -1;
        rst_at = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        x = 10'd5;
        y = 10'd7;
        wr_if.wr_en = 1'b0;
        w_addr = 0; w_valid = 0; w_type = 0; w_x = 0; w_y = 0; w_col = 0;
        drive_wr();
        repeat (2) @(posedge pixel_clk);
        #1;
        check("rst_x_out",    int'(x_out),         0);
        check("rst_y_out",    int'(y_out),         0);
        check("rst_hit",      int'(hit),           0);
        check("rst_type",     int'(element_type),  6);
        check("rst_ex",       int'(element_x),     0);
        check("rst_ey",       int'(element_y),     0);
        check("rst_color",    int'(sprite_color),  0);
        check("rst_ovf",      int'(line_overflow), 0);
        rst_n = 1'b1;

        // Single element: entry 3, type 1 at (100, 50), colour 2.
        write_entry(3, 1, 1, 100, 50, 2);
        run_line(49);
        check("single_l49_hits", ln_hits, 0);
        run_line(50);
        check("single_l50_hits",  ln_hits,  32);
        check("single_l50_first", ln_first, 100);
        check("single_l50_last",  ln_last,  131);
        check("single_l50_type",  ln_type,  1);
        check("single_l50_ex",    ln_ex,    100);
        check("single_l50_ey",    ln_ey,    50);
        check("single_l50_color", ln_col,   2);
        check("single_l50_yout",  ln_yout,  50);
        run_line(80);
        run_line(81);
        check("single_l81_hits",  ln_hits,  32);
        run_line(82);
        check("single_l82_hits",  ln_hits,  0);
        write_entry(3, 0, 0, 0, 0, 0);

        // Priority: entries 0 and 5 at the same spot.
        write_entry(0, 1, 0, 200, 200, 1);
        write_entry(5, 1, 5, 200, 200, 3);
        run_line(199);
        run_line(200);
        check("prio_hits",  ln_hits,  32);
        check("prio_first", ln_first, 200);
        check("prio_type",  ln_type,  0);
        check("prio_color", ln_col,   1);
        check("prio_type5", ln_type5, 0);
        write_entry(0, 0, 0, 0, 0, 0);
        write_entry(5, 0, 0, 0, 0, 0);

        // Overflow: six entries on line 100.
        for (int i = 0; i < 6; i++) write_entry(i, 1, 1, 40 * i, 100, 1);
        run_line(98);
        check("ovf_l98_pulses", ln_ovf, 0);
        run_line(99);
        check("ovf_l99_pulses", ln_ovf,   1);
        check("ovf_l99_x",      ln_ovf_x, 656);
        run_line(100);
        check("ovf_l100_hits",  ln_hits,  128);
        check("ovf_hit_x0",     int'(ln_map[0]),   1);
        check("ovf_hit_x120",   int'(ln_map[120]), 1);
        check("ovf_hit_x160",   int'(ln_map[160]), 0);
        check("ovf_hit_x200",   int'(ln_map[200]), 0);
        for (int i = 0; i < 6; i++) write_entry(i, 0, 0, 0, 0, 0);

        // Edges: right-clipped element and an element on line 0.
        write_entry(2, 1, 2, 620, 300, 1);
        write_entry(7, 1, 3, 10, 0, 2);
        run_line(299);
        run_line(300);
        check("clip_hits",  ln_hits,  20);
        check("clip_first", ln_first, 620);
        check("clip_last",  ln_last,  639);
        run_line(524);
        run_line(0);
        check("top_hits",  ln_hits,  32);
        check("top_first", ln_first, 10);
        check("top_type",  ln_type,  3);
        check("top_ey",    ln_ey,    0);
        write_entry(2, 0, 0, 0, 0, 0);
        write_entry(7, 0, 0, 0, 0, 0);

        // Write/scan collision on entry 4 at x = 644.
        write_entry(4, 1, 1, 300, 400, 1);
        run_line(398);
        w_addr = 4; w_valid = 1; w_type = 2; w_x = 500; w_y = 400; w_col = 3;
        wr_at = 644;
        run_line(399);
        run_line(400);
        check("coll_old_first", ln_first, 300);
        check("coll_old_type",  ln_type,  1);
        run_line(401);
        check("coll_new_first", ln_first, 500);
        check("coll_new_type",  ln_type,  2);

        // Reset mid-scan at x = 648.
        rst_at = 648;
        run_line(402);
        check("mrst_x_out", rs_snap[0], 0);
        check("mrst_y_out", rs_snap[1], 0);
        check("mrst_hit",   rs_snap[2], 0);
        check("mrst_type",  rs_snap[3], 6);
        check("mrst_ex",    rs_snap[4], 0);
        check("mrst_ey",    rs_snap[5], 0);
        check("mrst_color", rs_snap[6], 0);
        check("mrst_ovf",   rs_snap[7], 0);
        run_line(403);
        check("mrst_next_line_hits", ln_hits, 0);
        run_line(404);
        check("mrst_table_empty_hits", ln_hits, 0);

        check("x_y_alignment_errors", bad_align, 0);
        check("no_hit_field_errors",  bad_none,  0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/element_scanner.md
# element_scanner

Per-scanline object selector that feeds `pixel_graphics`. It holds a 16-entry element table written by game logic. During each horizontal blank it scans the table for elements that overlap the next visible line. During active video it emits, per pixel, the highest-priority element covering that pixel, plus pixel coordinates delayed to match.

## Interface
- `NUM_ENTRIES`, 16: element table depth; index 0 has the highest priority.
- `LINE_SLOTS`, 4: maximum elements kept per scanline.
- `SPRITE_W`, 32: sprite width and height in pixels.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_TOTAL`, 800: pixels per line, including blank.
- `V_TOTAL`, 525: lines per frame.

Ports:
- `pixel_clk` in 1: pixel clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `x` in 10: current horizontal counter, 0..799, from the timing generator.
- `y` in 10: current vertical counter, 0..524.
- `wr_en` in 1: table write strobe.
- `wr_addr` in 4: table entry to write.
- `wr_valid` in 1: entry enable.
- `wr_type` in 3: element type (0 ship, 1-3 aliens, 4 explosion, 5 rocket).
- `wr_x` in 10: element left edge.
- `wr_y` in 10: element top edge.
- `wr_color` in 2: sprite colour code.
- `x_out` in… out 10: `x` delayed by 1 cycle.
- `y_out` out 10: `y` delayed by 1 cycle.
- `hit` out 1: an element covers (`x_out`, `y_out`).
- `element_type` out 3: type of the covering element; 3'b110 (NONE) when `hit` = 0.
- `element_x` out 10: left edge of the covering element; 0 when `hit` = 0.
- `element_y` out 10: top edge of the covering element; 0 when `hit` = 0.
- `sprite_color` out 2: colour of the covering element; 0 when `hit` = 0.
- `line_overflow` out 1: one-cycle pulse when a scan finds more than `LINE_SLOTS` matches.

## Operation
- **Table writes**
  - When `wr_en` = 1, the entry at `wr_addr` is fully overwritten at the clock edge.
  - Writes are allowed in any cycle.
- **Target line**
  - `t = (y == V_TOTAL-1) ? 0 : y+1`.
  - `t` is latched at scan start.
- **Scanner FSM**
  - States: IDLE, SCAN, WAIT.
  - IDLE → SCAN when `x == H_ACTIVE` (640). At that transition, clear the next list and set `idx = 0`.
  - SCAN tests entry `idx` for one cycle each, so the scan covers x = 640..655. Then SCAN → WAIT.
  - Match condition: `valid && t >= ey && t < ey + SPRITE_W`, evaluated in 11-bit arithmetic so there is no wrap.
  - Matches fill next-list slots in ascending index order.
  - Any match found while the list is already full is dropped, and `line_overflow` pulses once in the cycle after the scan ends.
  - WAIT → IDLE at `x == H_TOTAL-1` (799). In that same cycle the next list is copied into the active list.
- **Write/scan collision**
  - A write to the entry being scanned in the same cycle is not seen: the scanner uses the pre-write value.
- **Pixel select** (runs every cycle)
  - Slot s hits if `x < H_ACTIVE && x >= ex_s && x < ex_s + SPRITE_W`, using 11-bit arithmetic.
  - The lowest occupied slot that hits wins.
  - The result is registered into the outputs.
- **Reset**
  - Applies when `rst_n` = 0 at a clock edge, including mid-scan.
  - All table valid bits cleared; both lists emptied; FSM goes to IDLE.
  - Output values after reset: `x_out` = 0, `y_out` = 0, `hit` = 0, `element_type` = NONE, `element_x` = 0, `element_y` = 0, `sprite_color` = 0, `line_overflow` = 0.
  - Lines before the first complete post-reset scan show no elements.

## Timing
- Latency is 1 cycle: the outputs at edge n+1 describe (`x`, `y`) sampled at edge n.
- `x_out` and `y_out` are aligned with the element outputs, so `pixel_graphics` computes `y_out - element_y` and `x_out - element_x` directly.
- A table write at any point during line L becomes visible no earlier than line L+2 if it lands after the scan has read that entry, or L+1 if it lands before.
- A scan always completes by x = 656, well inside the 160-cycle blank.
- `x` is assumed to advance by 1 per cycle, but the FSM keys only on x = 640 and x = 799. If `x` skips 640, no scan runs and the active list is still replaced (by an empty list) at 799.
- Element at `wr_y` = 500 on a 525-line frame: it matches lines 500..524 only. There is no vertical wrap into line 0.

## Test plan
- **Single element.** Write entry 3 (type 1, x = 100, y = 50, colour 2), then run a frame. Required: `hit` = 1 exactly for `x_out` 100..131 on `y_out` 50..81, with `element_type` = 1, `element_x` = 100, `element_y` = 50, `sprite_color` = 2. `hit` = 0 everywhere else.
- **Priority.** Entries 0 and 5 both at (200, 200), types 0 and 5. Required: output shows type 0 over 200..231; entry 5 is never visible.
- **Overflow.** Six valid entries all at y = 100, x = 0, 40, 80, 120, 160, 200. Required on line 100: entries 0-3 shown, x = 160 and 200 show `hit` = 0. `line_overflow` pulses once at x = 656 of line 99.
- **Edges.** Element at x = 620 (right edge clipped), and another at y = 0. Required: `hit` for `x_out` 620..639 only. The y = 0 element is visible on line 0, with the scan that produces it running during the hblank of line 524.
- **Write/scan collision.** Write entry 4 in the same cycle the scanner reads it (x = 644). Required: the old value is used for the next line; the new value appears one line later.
- **Reset mid-scan.** Assert `rst_n` = 0 for 1 cycle at x = 648. Required: every output is at its reset value on the following edge, no element is shown on the next line, and the table is empty.
